// File: rtl/des_uart_cmd_engine.sv
// des_uart_cmd_engine: UART host-command framing engine in front of a block-cipher core
// Ports: Clk/Rst (async, active high); i_fRx/i_RxData UART RX byte strobe;
//   i_fTxReady/i_fTxDone and o_fTx/o_TxData UART TX byte handshake;
//   o_CmdValid/i_CmdReady/o_CmdOp/o_CmdData command to core; i_fCoreDone/i_CoreData core result;
//   o_Busy high outside IDLE; o_DropCnt saturating count of bytes received while not parsing.
module des_uart_cmd_engine #(
  parameter int DW = 64,
  parameter int TIMEOUT = 100000,
  parameter logic [7:0] OP_SETKEY = 8'h00,
  parameter logic [7:0] OP_ENC = 8'h02,
  parameter logic [7:0] OP_DEC = 8'h03
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_fRx,
  input  logic [7:0]    i_RxData,
  input  logic          i_fTxReady,
  input  logic          i_fTxDone,
  output logic          o_fTx,
  output logic [7:0]    o_TxData,
  output logic          o_CmdValid,
  input  logic          i_CmdReady,
  output logic [1:0]    o_CmdOp,
  output logic [DW-1:0] o_CmdData,
  input  logic          i_fCoreDone,
  input  logic [DW-1:0] i_CoreData,
  output logic          o_Busy,
  output logic [7:0]    o_DropCnt
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, PAYLOAD, ISSUE, WAIT, TX_STAT, TX_DATA} state_t;
  state_t r_state, w_next;
  logic [1:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_data, r_res;
  logic [7:0]    r_stat, r_TxData, r_drop;
  logic          r_out, r_fTx;
  logic          w_op_ok, w_last, w_tmo, w_tx_go, w_done;
  logic [1:0]    w_op_code;
  assign w_op_ok   = i_RxData == OP_SETKEY || i_RxData == OP_ENC || i_RxData == OP_DEC;
  assign w_op_code = i_RxData == OP_ENC ? 2'd1 : i_RxData == OP_DEC ? 2'd2 : 2'd0;
  assign w_last    = r_cnt == CW'(NB - 1);
  assign w_tmo     = r_timer == TW'(TIMEOUT - 1);
  // r_out tracks a byte handed to UART_TX whose done strobe has not yet come back
  assign w_tx_go   = i_fTxReady && !r_out;
  assign w_done    = i_fTxDone && r_out;
  assign o_fTx      = r_fTx;
  assign o_TxData   = r_TxData;
  assign o_CmdValid = r_state == ISSUE;
  assign o_CmdOp    = r_op;
  assign o_CmdData  = r_data;
  assign o_Busy     = r_state != IDLE;
  assign o_DropCnt  = r_drop;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_fRx) w_next = w_op_ok ? PAYLOAD : TX_STAT;
      PAYLOAD: w_next = i_fRx ? (w_last ? ISSUE : PAYLOAD) : (w_tmo ? TX_STAT : PAYLOAD);
      ISSUE:   if (i_CmdReady) w_next = WAIT;
      WAIT:    if (i_fCoreDone) w_next = TX_STAT;
      TX_STAT: if (w_done) w_next = (r_op == 2'd0 || r_stat != 8'h00) ? IDLE : TX_DATA;
      TX_DATA: if (w_done && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_data   <= '0;
      r_res    <= '0;
      r_stat   <= '0;
      r_TxData <= '0;
      r_drop   <= '0;
      r_out    <= 1'b0;
      r_fTx    <= 1'b0;
    end else begin
      r_fTx <= 1'b0;
      if (i_fRx && r_state != IDLE && r_state != PAYLOAD && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      case (r_state)
        // status preset to bad-opcode; only reaches the host if the opcode is rejected
        IDLE: if (i_fRx) begin
          r_op    <= w_op_code;
          r_cnt   <= '0;
          r_timer <= '0;
          r_stat  <= 8'hE0;
        end
        // status preset to timeout; overwritten by the core result on a completed frame
        PAYLOAD: if (i_fRx) begin
          r_data  <= {r_data[DW-9:0], i_RxData};
          r_cnt   <= r_cnt + 1'b1;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
          r_stat  <= 8'hE1;
        end
        WAIT: if (i_fCoreDone) begin
          r_res  <= i_CoreData;
          r_stat <= 8'h00;
        end
        TX_STAT, TX_DATA: begin
          if (w_tx_go) begin
            r_fTx    <= 1'b1;
            r_out    <= 1'b1;
            r_TxData <= r_state == TX_STAT ? r_stat : r_res[DW-1 -: 8];
          end
          if (w_done) begin
            r_out <= 1'b0;
            r_cnt <= r_state == TX_STAT ? '0 : r_cnt + 1'b1;
            if (r_state == TX_DATA) r_res <= r_res << 8;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_des_uart_cmd_engine.sv
// tb_des_uart_cmd_engine: directed scoreboard bench for des_uart_cmd_engine at DW=64 and DW=128
module tb_des_uart_cmd_engine;
  logic Clk = 1'b0, Rst = 1'b1;
  always #5 Clk = ~Clk;
  logic a_fRx = 0, a_fTxReady = 1, a_fTxDone = 0, a_CmdReady = 0, a_fCoreDone = 0;
  logic [7:0] a_RxData = 0;
  logic [63:0] a_CoreData = 0;
  logic a_fTx, a_CmdValid, a_Busy;
  logic [7:0] a_TxData, a_DropCnt;
  logic [1:0] a_CmdOp;
  logic [63:0] a_CmdData;
  logic b_fRx = 0, b_fTxReady = 1, b_fTxDone = 0, b_CmdReady = 0, b_fCoreDone = 0;
  logic [7:0] b_RxData = 0;
  logic [127:0] b_CoreData = 0;
  logic b_fTx, b_CmdValid, b_Busy;
  logic [7:0] b_TxData, b_DropCnt;
  logic [1:0] b_CmdOp;
  logic [127:0] b_CmdData;
  des_uart_cmd_engine #(.DW(64), .TIMEOUT(50)) u_a (
    .Clk(Clk), .Rst(Rst), .i_fRx(a_fRx), .i_RxData(a_RxData), .i_fTxReady(a_fTxReady),
    .i_fTxDone(a_fTxDone), .o_fTx(a_fTx), .o_TxData(a_TxData), .o_CmdValid(a_CmdValid),
    .i_CmdReady(a_CmdReady), .o_CmdOp(a_CmdOp), .o_CmdData(a_CmdData), .i_fCoreDone(a_fCoreDone),
    .i_CoreData(a_CoreData), .o_Busy(a_Busy), .o_DropCnt(a_DropCnt));
  des_uart_cmd_engine #(.DW(128), .TIMEOUT(1000)) u_b (
    .Clk(Clk), .Rst(Rst), .i_fRx(b_fRx), .i_RxData(b_RxData), .i_fTxReady(b_fTxReady),
    .i_fTxDone(b_fTxDone), .o_fTx(b_fTx), .o_TxData(b_TxData), .o_CmdValid(b_CmdValid),
    .i_CmdReady(b_CmdReady), .o_CmdOp(b_CmdOp), .o_CmdData(b_CmdData), .i_fCoreDone(b_fCoreDone),
    .i_CoreData(b_CoreData), .o_Busy(b_Busy), .o_DropCnt(b_DropCnt));
  int errs = 0, checks = 0, a_vcnt = 0, v;
  logic [7:0] qa[$], qb[$];
  logic [7:0] ea, eb;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic send(input bit s, input logic [7:0] d);
    if (s) begin b_RxData = d; b_fRx = 1; end
    else begin a_RxData = d; a_fRx = 1; end
    tick();
    a_fRx = 0;
    b_fRx = 0;
  endtask
  task automatic frame(input bit s, input logic [7:0] op, input logic [127:0] d, input int n, input int gap);
    send(s, op);
    repeat (gap) tick();
    for (int i = 0; i < n; i++) begin
      send(s, d[8*(n-i)-1 -: 8]);
      if (i == n - 1 && n == (s ? 16 : 8)) chk("cmd_latency", s ? b_CmdValid : a_CmdValid, 1);
      else repeat (gap) tick();
    end
  endtask
  task automatic expect_tx(input bit s, input logic [7:0] st, input logic [127:0] r, input int n);
    if (s) qb.push_back(st); else qa.push_back(st);
    for (int i = 0; i < n; i++)
      if (s) qb.push_back(r[8*(n-i)-1 -: 8]); else qa.push_back(r[8*(n-i)-1 -: 8]);
  endtask
  task automatic core(input bit s, input logic [1:0] op, input logic [127:0] d, input logic [127:0] r,
                      input int stall, input int drops);
    int n = 0;
    while ((s ? b_CmdValid : a_CmdValid) !== 1'b1 && n < 200) begin tick(); n++; end
    chk("cmd_valid", s ? b_CmdValid : a_CmdValid, 1);
    chk("cmd_op", s ? b_CmdOp : a_CmdOp, op);
    chk("cmd_data", s ? b_CmdData : {64'h0, a_CmdData}, d);
    repeat (stall) begin tick(); chk("cmd_hold", s ? b_CmdValid : a_CmdValid, 1); end
    if (s) b_CmdReady = 1; else a_CmdReady = 1;
    tick();
    a_CmdReady = 0;
    b_CmdReady = 0;
    chk("cmd_valid_low", s ? b_CmdValid : a_CmdValid, 0);
    for (int i = 0; i < drops; i++) send(s, 8'hA0 + 8'(i));
    repeat (2) tick();
    if (s) begin b_CoreData = r; b_fCoreDone = 1; end
    else begin a_CoreData = r[63:0]; a_fCoreDone = 1; end
    tick();
    a_fCoreDone = 0;
    b_fCoreDone = 0;
  endtask
  task automatic wait_idle(input bit s);
    int n = 0;
    while (((s ? b_Busy : a_Busy) || (s ? qb.size() : qa.size()) != 0) && n < 2000) begin tick(); n++; end
    chk("idle", s ? b_Busy : a_Busy, 0);
    chk("tx_drained", (s ? qb.size() : qa.size()) == 0, 1);
  endtask
  always @(posedge Clk) if (a_CmdValid === 1'b1) a_vcnt++;
  initial forever begin
    @(negedge Clk);
    if (a_fTx === 1'b1) begin
      chk("a_tx_expected", qa.size() != 0, 1);
      ea = qa.size() != 0 ? qa.pop_front() : 8'h00;
      chk("a_tx_byte", a_TxData, ea);
      a_fTxReady = 0;
      repeat (3) begin @(negedge Clk); chk("a_tx_no_refire", a_fTx, 0); end
      a_fTxDone = 1;
      a_fTxReady = 1;
      @(negedge Clk);
      a_fTxDone = 0;
      chk("a_tx_hold", a_TxData, ea);
    end
  end
  initial forever begin
    @(negedge Clk);
    if (b_fTx === 1'b1) begin
      chk("b_tx_expected", qb.size() != 0, 1);
      eb = qb.size() != 0 ? qb.pop_front() : 8'h00;
      chk("b_tx_byte", b_TxData, eb);
      b_fTxReady = 0;
      repeat (2) begin @(negedge Clk); chk("b_tx_no_refire", b_fTx, 0); end
      b_fTxDone = 1;
      b_fTxReady = 1;
      @(negedge Clk);
      b_fTxDone = 0;
      chk("b_tx_hold", b_TxData, eb);
    end
  end
  initial begin
    repeat (3) tick();
    chk("rst_fTx", a_fTx, 0);
    chk("rst_CmdValid", a_CmdValid, 0);
    chk("rst_Busy", a_Busy, 0);
    chk("rst_TxData", a_TxData, 0);
    chk("rst_CmdOp", a_CmdOp, 0);
    chk("rst_CmdData", a_CmdData, 0);
    chk("rst_DropCnt", a_DropCnt, 0);
    chk("rst_b_Busy", b_Busy, 0);
    Rst = 0;
    tick();
    frame(0, 8'h02, 128'h102030, 3, 1);
    chk("t1_busy", a_Busy, 1);
    chk("t1_shift", a_CmdData, 64'h102030);
    chk("t1_op", a_CmdOp, 1);
    Rst = 1;
    #1;
    chk("t1_rst_Busy", a_Busy, 0);
    chk("t1_rst_CmdOp", a_CmdOp, 0);
    chk("t1_rst_CmdData", a_CmdData, 0);
    chk("t1_rst_CmdValid", a_CmdValid, 0);
    chk("t1_rst_fTx", a_fTx, 0);
    tick();
    Rst = 0;
    tick();
    expect_tx(0, 8'h00, 128'h0, 0);
    frame(0, 8'h00, 128'h1020304050607080, 8, 1);
    core(0, 2'd0, 128'h1020304050607080, 128'hDEADBEEFCAFEF00D, 0, 0);
    wait_idle(0);
    expect_tx(0, 8'h00, 128'h83D8AFEF97D1D369, 8);
    frame(0, 8'h02, 128'h0102030405060708, 8, 1);
    core(0, 2'd1, 128'h0102030405060708, 128'h83D8AFEF97D1D369, 2, 0);
    wait_idle(0);
    expect_tx(0, 8'h00, 128'h0102030405060708, 8);
    frame(0, 8'h03, 128'h83D8AFEF97D1D369, 8, 0);
    core(0, 2'd2, 128'h83D8AFEF97D1D369, 128'h0102030405060708, 0, 0);
    wait_idle(0);
    v = a_vcnt;
    expect_tx(0, 8'hE0, 128'h0, 0);
    send(0, 8'h07);
    wait_idle(0);
    chk("t5_badop_no_valid", a_vcnt == v, 1);
    expect_tx(0, 8'hE1, 128'h0, 0);
    frame(0, 8'h02, 128'hAABBCC, 3, 1);
    wait_idle(0);
    chk("t5_timeout_no_valid", a_vcnt == v, 1);
    expect_tx(0, 8'h00, 128'hF0E1D2C3B4A59687, 8);
    frame(0, 8'h02, 128'h1122334455667788, 8, 49);
    core(0, 2'd1, 128'h1122334455667788, 128'hF0E1D2C3B4A59687, 0, 0);
    wait_idle(0);
    expect_tx(0, 8'hE1, 128'h0, 0);
    frame(0, 8'h02, 128'h55, 1, 50);
    wait_idle(0);
    chk("t5_late_byte_dropped", a_DropCnt, 1);
    expect_tx(1, 8'h00, 128'h00112233445566778899AABBCCDDEEFF, 16);
    frame(1, 8'h02, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 16, 1);
    core(1, 2'd1, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 128'h00112233445566778899AABBCCDDEEFF, 20, 4);
    wait_idle(1);
    chk("t6_dropcnt", b_DropCnt, 4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
